// File: rtl/systolic_drain_pkg.sv
// Shared constants, FSM encoding and INT8 bounds for the systolic array drain.
package systolic_drain_pkg;

    localparam int ARRAY_SIZE      = 32;
    localparam int DATA_WIDTH      = 8;
    localparam int OUTCOME_WIDTH   = 2 * DATA_WIDTH + 5;
    localparam int SRAM_DATA_WIDTH = 32;

    localparam int LANES_PER_WORD  = SRAM_DATA_WIDTH / DATA_WIDTH;
    localparam int WORDS_PER_ROW   = ARRAY_SIZE / LANES_PER_WORD;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2,
        DONE  = 2'd3
    } drain_state_e;

endpackage

// File: rtl/systolic_drain_if.sv
// SRAM write-side bundle: one packed output row plus its valid/ready handshake.
interface systolic_drain_if;
    import systolic_drain_pkg::*;

    logic [SRAM_DATA_WIDTH-1:0] sram_wdata0;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata1;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata2;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata3;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata4;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata5;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata6;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata7;
    logic [4:0]                 sram_waddr;
    logic                       wr_valid;
    logic                       wr_ready;

    modport master (
        output sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3,
        output sram_wdata4, sram_wdata5, sram_wdata6, sram_wdata7,
        output sram_waddr, wr_valid,
        input  wr_ready
    );

    modport slave (
        input  sram_wdata0, sram_wdata1, sram_wdata2, sram_wdata3,
        input  sram_wdata4, sram_wdata5, sram_wdata6, sram_wdata7,
        input  sram_waddr, wr_valid,
        output wr_ready
    );

endinterface

// File: rtl/systolic_drain_requant.sv
// Single-lane requantizer: round-half-up, arithmetic shift, INT8 saturate, optional ReLU.
module drain_requant
    import systolic_drain_pkg::*;
(
    input  logic signed [OUTCOME_WIDTH-1:0] x,
    input  logic        [4:0]               shift_amt,
    input  logic                            relu_en,
    output logic signed [DATA_WIDTH-1:0]    y
);

    // Wide enough that the rounding constant for any 5-bit shift never wraps,
    // so large shifts collapse cleanly to 0 or -1.
    localparam int WIDE_W = 34;
    localparam logic signed [WIDE_W-1:0] SAT_HI = WIDE_W'(INT8_MAX);
    localparam logic signed [WIDE_W-1:0] SAT_LO = WIDE_W'(INT8_MIN);

    function automatic logic signed [WIDE_W-1:0] round_shift(
        input logic signed [OUTCOME_WIDTH-1:0] v,
        input logic        [4:0]               s
    );
        logic signed [WIDE_W-1:0] wide;
        logic signed [WIDE_W-1:0] half;
        wide = {{(WIDE_W-OUTCOME_WIDTH){v[OUTCOME_WIDTH-1]}}, v};
        if (s == 5'd0) begin
            return wide;
        end
        half = WIDE_W'(1) << (s - 5'd1);
        return (wide + half) >>> s;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] saturate(
        input logic signed [WIDE_W-1:0] r
    );
        logic signed [WIDE_W-1:0] c;
        c = r;
        if (r > SAT_HI) c = SAT_HI;
        if (r < SAT_LO) c = SAT_LO;
        return c[DATA_WIDTH-1:0];
    endfunction

    logic signed [DATA_WIDTH-1:0] sat;

    // Requantize the lane and clamp negatives when ReLU is enabled.
    always_comb begin
        sat = saturate(round_shift(x, shift_amt));
        y   = (relu_en && sat[DATA_WIDTH-1]) ? '0 : sat;
    end

endmodule

// File: rtl/systolic_drain.sv
// Drains the systolic array row by row: fetch a result vector, requantize all
// lanes, and hand the packed row to the SRAM writer over valid/ready.
module systolic_drain
    import systolic_drain_pkg::*;
(
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                drain_start,
    input  logic [4:0]                          shift_amt,
    input  logic                                relu_en,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic [5:0]                          matrix_index,
    systolic_drain_if.master                    wr,
    output logic                                busy,
    output logic                                drain_done
);

    drain_state_e state_q, state_d;

    logic [4:0] idx_q;
    logic [4:0] shift_q;
    logic       relu_q;
    logic [4:0] waddr_q;
    logic       valid_q;
    logic       hs;
    logic       last_row;

    logic [WORDS_PER_ROW-1:0][SRAM_DATA_WIDTH-1:0] wdata_q;
    logic [WORDS_PER_ROW-1:0][SRAM_DATA_WIDTH-1:0] row_word;
    logic signed [DATA_WIDTH-1:0]                  lane_y [ARRAY_SIZE];

    assign hs       = valid_q & wr.wr_ready;
    assign last_row = (idx_q == 5'(ARRAY_SIZE - 1));

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        drain_requant u_requant (
            .x         (mul_outcome[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]),
            .shift_amt (shift_q),
            .relu_en   (relu_q),
            .y         (lane_y[i])
        );
    end

    // Pack lanes big-endian within each word: lane 4w+b lands in byte b from the top.
    always_comb begin
        row_word = '0;
        for (int w = 0; w < WORDS_PER_ROW; w++) begin
            for (int b = 0; b < LANES_PER_WORD; b++) begin
                row_word[w][SRAM_DATA_WIDTH-1-DATA_WIDTH*b -: DATA_WIDTH] = lane_y[LANES_PER_WORD*w+b];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; a start outside IDLE is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (drain_start) state_d = FETCH;
            FETCH:   state_d = OUT;
            OUT:     if (hs) state_d = last_row ? DONE : FETCH;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row index, captured settings, output row and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q        <= '0;
            shift_q      <= '0;
            relu_q       <= 1'b0;
            matrix_index <= '0;
            wdata_q      <= '0;
            waddr_q      <= '0;
            valid_q      <= 1'b0;
            busy         <= 1'b0;
            drain_done   <= 1'b0;
        end else begin
            drain_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (drain_start) begin
                        shift_q      <= shift_amt;
                        relu_q       <= relu_en;
                        idx_q        <= '0;
                        matrix_index <= '0;
                        busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    wdata_q <= row_word;
                    waddr_q <= idx_q;
                    valid_q <= 1'b1;
                end
                OUT: begin
                    if (hs) begin
                        valid_q <= 1'b0;
                        if (!last_row) begin
                            idx_q        <= idx_q + 5'd1;
                            matrix_index <= {1'b0, idx_q + 5'd1};
                        end
                    end
                end
                DONE: begin
                    drain_done <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign wr.sram_wdata0 = wdata_q[0];
    assign wr.sram_wdata1 = wdata_q[1];
    assign wr.sram_wdata2 = wdata_q[2];
    assign wr.sram_wdata3 = wdata_q[3];
    assign wr.sram_wdata4 = wdata_q[4];
    assign wr.sram_wdata5 = wdata_q[5];
    assign wr.sram_wdata6 = wdata_q[6];
    assign wr.sram_wdata7 = wdata_q[7];
    assign wr.sram_waddr  = waddr_q;
    assign wr.wr_valid    = valid_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain with a behavioural array/requant model.
module tb_systolic_drain;
    import systolic_drain_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic drain_start;
    logic [4:0] shift_amt;
    logic relu_en;
    logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome;
    logic [5:0] matrix_index;
    logic busy;
    logic drain_done;

    systolic_drain_if wr();

    systolic_drain dut (
        .clk          (clk),
        .rst          (rst),
        .drain_start  (drain_start),
        .shift_amt    (shift_amt),
        .relu_en      (relu_en),
        .mul_outcome  (mul_outcome),
        .matrix_index (matrix_index),
        .wr           (wr),
        .busy         (busy),
        .drain_done   (drain_done)
    );

    always #5 clk = ~clk;

    // Array contents: result vector for each read index.
    logic signed [20:0] arr [32][32];

    always_comb begin
        mul_outcome = '0;
        for (int l = 0; l < 32; l++) mul_outcome[l*21 +: 21] = arr[matrix_index[4:0]][l];
    end

    logic [255:0] cur_row;
    assign cur_row = {wr.sram_wdata0, wr.sram_wdata1, wr.sram_wdata2, wr.sram_wdata3,
                      wr.sram_wdata4, wr.sram_wdata5, wr.sram_wdata6, wr.sram_wdata7};

    int checks = 0;
    int errors = 0;

    // Observations gathered by run_drain.
    logic [255:0] obs_row [64];
    int obs_addr [64];
    int obs_mi [64];
    int n_hs, n_done, done_cyc, n_unstable, stall_seen;
    bit timed_out, busy_mid, busy_after_done;

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && ((a < 0) != (b < 0))) q = q - 1;
        return q;
    endfunction

    function automatic logic [7:0] model_byte(input int x, input int s, input bit relu);
        longint r;
        longint p;
        if (s == 0) r = x;
        else begin
            p = longint'(1) << s;
            r = floor_div(longint'(x) + p / 2, p);
        end
        if (r > 127) r = 127;
        if (r < -128) r = -128;
        if (relu && r < 0) r = 0;
        return r[7:0];
    endfunction

    function automatic logic [255:0] model_row(input int idx, input int s, input bit relu);
        logic [255:0] row;
        row = '0;
        for (int l = 0; l < 32; l++) row[255 - 8*l -: 8] = model_byte(int'(arr[idx][l]), s, relu);
        return row;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 32; i++)
            for (int l = 0; l < 32; l++)
                arr[i][l] = 21'($urandom);
    endtask

    // Runs one drain; ready_mode 0=always ready, 1=random, 2=10-cycle stall at row 3.
    task automatic run_drain(input int s, input bit relu, input int ready_mode, input bit inject);
        int cyc, post, stall_left;
        bit prev_pending, rdy;
        logic [255:0] prev_row;
        int prev_addr;
        n_hs = 0; n_done = 0; done_cyc = -1; n_unstable = 0; stall_seen = 0;
        timed_out = 0; busy_mid = 0; busy_after_done = 1;
        post = 0; stall_left = 10; prev_pending = 0; prev_row = '0; prev_addr = 0;
        @(negedge clk);
        shift_amt = 5'(s);
        relu_en = relu;
        wr.wr_ready = (ready_mode == 0);
        drain_start = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        cyc = 0;
        while (!(done_cyc >= 0 && post >= 5)) begin
            if (cyc >= 3000) begin
                timed_out = 1;
                break;
            end
            if (drain_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after_done = busy;
            if (done_cyc >= 0) post++;
            if (cyc == 10) busy_mid = busy;
            if (prev_pending && (!wr.wr_valid || int'(wr.sram_waddr) != prev_addr || cur_row != prev_row))
                n_unstable++;
            case (ready_mode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    if (wr.wr_valid && wr.sram_waddr == 5'd3 && stall_left > 0) begin
                        rdy = 1'b0;
                        stall_left--;
                        stall_seen++;
                    end else rdy = 1'b1;
                end
            endcase
            wr.wr_ready = rdy;
            if (inject && cyc > 2 && cyc < 60 && $urandom_range(0, 3) == 0) begin
                drain_start = 1'b1;
                shift_amt = 5'($urandom);
            end else drain_start = 1'b0;
            if (wr.wr_valid && rdy) begin
                if (n_hs < 64) begin
                    obs_row[n_hs] = cur_row;
                    obs_addr[n_hs] = int'(wr.sram_waddr);
                    obs_mi[n_hs] = int'(matrix_index);
                end
                n_hs++;
                prev_pending = 0;
            end else if (wr.wr_valid) begin
                prev_pending = 1;
                prev_addr = int'(wr.sram_waddr);
                prev_row = cur_row;
            end else prev_pending = 0;
            @(posedge clk); #1;
            cyc++;
        end
        drain_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #23;
        checks++;
        if (wr.wr_valid !== 1'b0 || busy !== 1'b0 || drain_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: valid=%b busy=%b done=%b, required 0 0 0", wr.wr_valid, busy, drain_done);
        end
        checks++;
        if (matrix_index !== 6'd0 || wr.sram_waddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_index: mi=%0d waddr=%0d, required 0 0", matrix_index, wr.sram_waddr);
        end
        checks++;
        if (cur_row !== 256'd0) begin
            errors++;
            $display("FAIL reset_data: row=%h, required 0", cur_row);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        for (int i = 0; i < 32; i++)
            for (int l = 0; l < 32; l++) arr[i][l] = 21'sd5;
        run_drain(0, 0, 0, 0);
        checks++;
        if (timed_out || n_hs !== 32 || n_done !== 1) begin
            errors++;
            $display("FAIL basic_count: hs=%0d done=%0d timeout=%0d, required 32 1 0", n_hs, n_done, timed_out);
        end
        checks++;
        if (done_cyc !== 65) begin
            errors++;
            $display("FAIL basic_latency: done after %0d cycles, required 65", done_cyc);
        end
        checks++;
        if (busy_mid !== 1'b1 || busy_after_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy: mid=%b after_done=%b, required 1 0", busy_mid, busy_after_done);
        end
        checks++;
        if (obs_row[0] !== {8{32'h05050505}}) begin
            errors++;
            $display("FAIL basic_word: row=%h, required all 05050505", obs_row[0]);
        end
        for (int i = 0; i < 32 && i < n_hs; i++) begin
            checks++;
            if (obs_addr[i] !== i || obs_mi[i] !== i || obs_row[i] !== model_row(i, 0, 0)) begin
                errors++;
                $display("FAIL basic_row%0d: addr=%0d mi=%0d row=%h, required addr %0d row %h",
                         i, obs_addr[i], obs_mi[i], obs_row[i], i, model_row(i, 0, 0));
            end
        end
    endtask

    task automatic test_round_sat();
        fill_random();
        for (int i = 0; i < 32; i++) begin
            arr[i][0] = 21'sd24;
            arr[i][1] = 21'sd23;
            arr[i][2] = -21'sd24;
            arr[i][3] = 21'sd5000;
            arr[i][4] = -21'sd5000;
        end
        run_drain(4, 0, 0, 0);
        checks++;
        if (timed_out || n_hs !== 32) begin
            errors++;
            $display("FAIL round_count: hs=%0d timeout=%0d, required 32 0", n_hs, timed_out);
        end
        checks++;
        if (obs_row[0][255:216] !== 40'h0201FF7F80) begin
            errors++;
            $display("FAIL round_bytes: got %h, required 0201ff7f80", obs_row[0][255:216]);
        end
        for (int i = 0; i < 32 && i < n_hs; i++) begin
            checks++;
            if (obs_addr[i] !== i || obs_row[i] !== model_row(i, 4, 0)) begin
                errors++;
                $display("FAIL round_row%0d: addr=%0d row=%h, required %h", i, obs_addr[i], obs_row[i], model_row(i, 4, 0));
            end
        end
    endtask

    task automatic test_relu();
        fill_random();
        for (int i = 0; i < 32; i++)
            for (int l = 0; l < 32; l += 2) begin
                arr[i][l] = -21'sd3;
                arr[i][l+1] = 21'sd7;
            end
        arr[9][5] = -21'sd900000;
        run_drain(0, 1, 0, 0);
        checks++;
        if (timed_out || n_hs !== 32) begin
            errors++;
            $display("FAIL relu_count: hs=%0d timeout=%0d, required 32 0", n_hs, timed_out);
        end
        checks++;
        if (obs_row[0][255:240] !== 16'h0007) begin
            errors++;
            $display("FAIL relu_bytes: got %h, required 0007", obs_row[0][255:240]);
        end
        for (int i = 0; i < 32 && i < n_hs; i++) begin
            checks++;
            if (obs_row[i] !== model_row(i, 0, 1)) begin
                errors++;
                $display("FAIL relu_row%0d: row=%h, required %h", i, obs_row[i], model_row(i, 0, 1));
            end
        end
    endtask

    task automatic test_random();
        int s;
        bit relu;
        for (int t = 0; t < 4; t++) begin
            fill_random();
            s = (t == 3) ? 23 : int'($urandom_range(0, 21));
            relu = 1'($urandom_range(0, 1));
            run_drain(s, relu, 1, 0);
            checks++;
            if (timed_out || n_hs !== 32 || n_done !== 1 || n_unstable !== 0) begin
                errors++;
                $display("FAIL random%0d_flow: hs=%0d done=%0d unstable=%0d timeout=%0d, required 32 1 0 0",
                         t, n_hs, n_done, n_unstable, timed_out);
            end
            for (int i = 0; i < 32 && i < n_hs; i++) begin
                checks++;
                if (obs_addr[i] !== i || obs_row[i] !== model_row(i, s, relu)) begin
                    errors++;
                    $display("FAIL random%0d_row%0d: s=%0d relu=%0d addr=%0d row=%h, required %h",
                             t, i, s, relu, obs_addr[i], obs_row[i], model_row(i, s, relu));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        fill_random();
        run_drain(6, 0, 2, 0);
        checks++;
        if (stall_seen !== 10 || n_unstable !== 0) begin
            errors++;
            $display("FAIL bp_stable: stalled=%0d unstable=%0d, required 10 0", stall_seen, n_unstable);
        end
        checks++;
        if (timed_out || n_hs !== 32 || n_done !== 1) begin
            errors++;
            $display("FAIL bp_count: hs=%0d done=%0d timeout=%0d, required 32 1 0", n_hs, n_done, timed_out);
        end
        for (int i = 0; i < 32 && i < n_hs; i++) begin
            checks++;
            if (obs_addr[i] !== i || obs_row[i] !== model_row(i, 6, 0)) begin
                errors++;
                $display("FAIL bp_row%0d: addr=%0d row=%h, required %h", i, obs_addr[i], obs_row[i], model_row(i, 6, 0));
            end
        end
    endtask

    task automatic test_start_ignored();
        fill_random();
        run_drain(3, 0, 0, 1);
        checks++;
        if (timed_out || n_hs !== 32 || n_done !== 1 || done_cyc !== 65) begin
            errors++;
            $display("FAIL ignore_flow: hs=%0d done=%0d at %0d timeout=%0d, required 32 1 at 65 0",
                     n_hs, n_done, done_cyc, timed_out);
        end
        for (int i = 0; i < 32 && i < n_hs; i++) begin
            checks++;
            if (obs_addr[i] !== i || obs_row[i] !== model_row(i, 3, 0)) begin
                errors++;
                $display("FAIL ignore_row%0d: addr=%0d row=%h, required %h", i, obs_addr[i], obs_row[i], model_row(i, 3, 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int stray;
        fill_random();
        found = 0;
        stray = 0;
        @(negedge clk);
        shift_amt = 5'd2;
        relu_en = 1'b0;
        wr.wr_ready = 1'b1;
        drain_start = 1'b1;
        @(posedge clk); #1;
        drain_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (wr.wr_valid && wr.sram_waddr == 5'd5) begin
                found = 1;
                wr.wr_ready = 1'b0;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL midrst_reach: row 5 never presented, required within 200 cycles");
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (wr.wr_valid !== 1'b0 || busy !== 1'b0 || matrix_index !== 6'd0) begin
            errors++;
            $display("FAIL midrst_clear: valid=%b busy=%b mi=%0d, required 0 0 0", wr.wr_valid, busy, matrix_index);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wr.wr_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (wr.wr_valid || busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL midrst_idle: %0d active cycles after reset, required 0", stray);
        end
        run_drain(2, 0, 0, 0);
        checks++;
        if (timed_out || n_hs !== 32 || obs_addr[0] !== 0) begin
            errors++;
            $display("FAIL midrst_restart: hs=%0d first_addr=%0d timeout=%0d, required 32 0 0", n_hs, obs_addr[0], timed_out);
        end
        for (int i = 0; i < 32 && i < n_hs; i++) begin
            checks++;
            if (obs_addr[i] !== i || obs_row[i] !== model_row(i, 2, 0)) begin
                errors++;
                $display("FAIL midrst_row%0d: addr=%0d row=%h, required %h", i, obs_addr[i], obs_row[i], model_row(i, 2, 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drain_start = 1'b0;
        shift_amt = '0;
        relu_en = 1'b0;
        wr.wr_ready = 1'b0;
        for (int i = 0; i < 32; i++)
            for (int l = 0; l < 32; l++) arr[i][l] = '0;
        test_reset();
        test_basic();
        test_round_sat();
        test_relu();
        test_random();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
